// File: rtl/dmem_responder.sv
// Data-memory responder: turns a single req/ready handshake into a timed
// asynchronous-SRAM cycle (setup, WAIT-cycle access, hold, response).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for req low; latches the transfer on the accepting edge
// SETUP  | chip enabled, address (and store data) driven, strobes high
// ACCESS | WAIT cycles with sram_oe (load) or sram_we (store) asserted
// HOLD   | strobes released, address/data/chip-enable held
// RESP   | ready pulsed low, SRAM released
module dmem_responder #(
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [16:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [14:0] sram_a,
  output logic [31:0] sram_dq_o,
  input  logic [31:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_ce,
  output logic        sram_oe,
  output logic [3:0]  sram_we
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

  logic [2:0] state;
  logic [3:0] cnt;
  logic       is_store;
  logic [3:0] be_q;

  // byte offset within the word has no meaning for a 32-bit SRAM
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^addr[1:0];

  // Every output is a register set on the transition into the state that
  // needs it, so nothing combinational reaches the pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      is_store   <= 1'b0;
      be_q       <= 4'hF;
      rdata      <= 32'h0;
      ready      <= 1'b1;
      sram_a     <= 15'h0;
      sram_dq_o  <= 32'h0;
      sram_dq_oe <= 1'b0;
      sram_ce    <= 1'b1;
      sram_oe    <= 1'b1;
      sram_we    <= 4'hF;
    end else begin
      case (state)
        S_IDLE: begin
          if (!req) begin
            state      <= S_SETUP;
            is_store   <= ~we;
            be_q       <= be;
            sram_a     <= addr[16:2];
            sram_dq_o  <= wdata;
            sram_dq_oe <= ~we;
            sram_ce    <= 1'b0;
          end
        end
        S_SETUP: begin
          state <= S_ACCESS;
          cnt   <= CNT_LOAD;
          if (is_store) begin
            sram_we <= be_q;
          end else begin
            sram_oe <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            state   <= S_HOLD;
            sram_oe <= 1'b1;
            sram_we <= 4'hF;
            if (!is_store) begin
              rdata <= sram_dq_i;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_HOLD: begin
          state      <= S_RESP;
          ready      <= 1'b0;
          sram_ce    <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
        S_RESP: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT = 2, 1, 15) against a
// transfer-timeline model and a word-array SRAM model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst        [3];
  logic        req        [3];
  logic        we         [3];
  logic [16:0] addr       [3];
  logic [31:0] wdata      [3];
  logic [3:0]  be         [3];
  logic [31:0] rdata      [3];
  logic        ready      [3];
  logic [14:0] sram_a     [3];
  logic [31:0] sram_dq_o  [3];
  logic [31:0] sram_dq_i  [3];
  logic        sram_dq_oe [3];
  logic        sram_ce    [3];
  logic        sram_oe    [3];
  logic [3:0]  sram_we    [3];

  logic        mem_init;
  logic [31:0] sram [3][64];

  int n_tests = 0;
  int n_fail  = 0;
  int oe_lo   [3] = '{0, 0, 0};
  int we_lo   [3] = '{0, 0, 0};
  int dqoe_hi [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  function automatic int wait_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  function automatic logic [31:0] pat(int k, int i);
    if (k == 0 && i == 4) return 32'hDEADBEEF;
    return {8'(8'hC0 + k), 8'(i), ~8'(i), 8'h5A};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.WAIT((g == 0) ? 2 : ((g == 1) ? 1 : 15))) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req        (req[g]),
      .we         (we[g]),
      .addr       (addr[g]),
      .wdata      (wdata[g]),
      .be         (be[g]),
      .rdata      (rdata[g]),
      .ready      (ready[g]),
      .sram_a     (sram_a[g]),
      .sram_dq_o  (sram_dq_o[g]),
      .sram_dq_i  (sram_dq_i[g]),
      .sram_dq_oe (sram_dq_oe[g]),
      .sram_ce    (sram_ce[g]),
      .sram_oe    (sram_oe[g]),
      .sram_we    (sram_we[g])
    );
    assign sram_dq_i[g] = (!sram_ce[g] && !sram_oe[g]) ? sram[g][sram_a[g][5:0]] : 32'h0;
  end

  // SRAM: per-lane writes while chip and lane write enables are low
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) begin
        if (mem_init) sram[k][i] <= pat(k, i);
      end
      if (!mem_init && !sram_ce[k]) begin
        for (int l = 0; l < 4; l++) begin
          if (!sram_we[k][l]) sram[k][sram_a[k][5:0]][8*l +: 8] <= sram_dq_o[k][8*l +: 8];
        end
      end
    end
  end

  // Transfer model: phase p counts cycles since the accepting edge
  // (1 setup, 2..W+1 access, W+2 hold, W+3 response).
  logic        m_busy [3];
  int          m_p    [3];
  logic        m_load [3];
  logic [14:0] m_a    [3];
  logic [31:0] m_d    [3];
  logic [3:0]  m_be   [3];
  logic [31:0] m_rd   [3];
  logic [31:0] m_mem  [3][64];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) begin
        if (mem_init) m_mem[k][i] <= pat(k, i);
      end
      if (!rst[k]) begin
        m_busy[k] <= 1'b0;
        m_p[k]    <= 0;
        m_rd[k]   <= 32'h0;
      end else if (m_busy[k]) begin
        m_p[k] <= m_p[k] + 1;
        if (m_p[k] + 1 == wait_of(k) + 2 && m_load[k]) m_rd[k] <= m_mem[k][m_a[k][5:0]];
        if (m_p[k] + 1 == wait_of(k) + 3 && !m_load[k]) begin
          for (int l = 0; l < 4; l++) begin
            if (!m_be[k][l]) m_mem[k][m_a[k][5:0]][8*l +: 8] <= m_d[k][8*l +: 8];
          end
        end
        if (m_p[k] + 1 == wait_of(k) + 4) m_busy[k] <= 1'b0;
      end else if (!req[k]) begin
        m_busy[k] <= 1'b1;
        m_p[k]    <= 1;
        m_load[k] <= we[k];
        m_a[k]    <= addr[k][16:2];
        m_d[k]    <= wdata[k];
        m_be[k]   <= be[k];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      int   p, w;
      logic acc, ld;
      logic e_ready, e_ce, e_oe, e_dqoe;
      logic [3:0] e_we;
      w  = wait_of(k);
      p  = (rst[k] && m_busy[k]) ? m_p[k] : 0;
      ld = m_load[k];
      acc     = (p >= 2) && (p <= w + 1);
      e_ready = !(p == w + 3);
      e_ce    = !((p >= 1) && (p <= w + 2));
      e_oe    = !(ld && acc);
      e_we    = (!ld && acc) ? m_be[k] : 4'hF;
      e_dqoe  = !ld && (p >= 1) && (p <= w + 2);
      chk($sformatf("ready[%0d]", k), 32'(ready[k]), 32'(e_ready));
      chk($sformatf("sram_ce[%0d]", k), 32'(sram_ce[k]), 32'(e_ce));
      chk($sformatf("sram_oe[%0d]", k), 32'(sram_oe[k]), 32'(e_oe));
      chk($sformatf("sram_we[%0d]", k), 32'(sram_we[k]), 32'(e_we));
      chk($sformatf("sram_dq_oe[%0d]", k), 32'(sram_dq_oe[k]), 32'(e_dqoe));
      chk($sformatf("bus_overlap[%0d]", k), 32'(sram_dq_oe[k] && !sram_oe[k]), 32'h0);
      assert (!(sram_dq_oe[k] && !sram_oe[k]))
        else $error("FAIL overlap[%0d]: sram_dq_oe and sram_oe both active", k);
      if (!rst[k]) begin
        chk($sformatf("rst_rdata[%0d]", k), rdata[k], 32'h0);
        chk($sformatf("rst_sram_a[%0d]", k), 32'(sram_a[k]), 32'h0);
        chk($sformatf("rst_dq_o[%0d]", k), sram_dq_o[k], 32'h0);
      end else begin
        chk($sformatf("rdata[%0d]", k), rdata[k], m_rd[k]);
        if (!e_ce) chk($sformatf("sram_a[%0d]", k), 32'(sram_a[k]), 32'(m_a[k]));
        if (e_dqoe) chk($sformatf("sram_dq_o[%0d]", k), sram_dq_o[k], m_d[k]);
      end
      if (!sram_oe[k]) oe_lo[k]++;
      if (sram_we[k] != 4'hF) we_lo[k]++;
      if (sram_dq_oe[k]) dqoe_hi[k]++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One transfer; inputs are scrambled right after acceptance.
  task automatic do_xfer(input int k, input logic w, input logic [16:0] ad,
                         input logic [31:0] wd, input logic [3:0] b,
                         output int lat, output logic [14:0] a_seen);
    we[k] = w; addr[k] = ad; wdata[k] = wd; be[k] = b; req[k] = 1'b0;
    step();
    req[k] = 1'b1; we[k] = ~w; addr[k] = 17'h1FFFF; wdata[k] = ~wd; be[k] = ~b;
    lat = 0;
    a_seen = 15'h0;
    for (int c = 1; c <= 40; c++) begin
      sample();
      if (c == 1) a_seen = sram_a[k];
      if (!ready[k]) begin
        lat = c;
        break;
      end
      step();
    end
    step();
    sample();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, oe0, we0, dq0, n_rdy;
    logic [14:0] as;
    int          rdy_cyc [3];
    logic        saw_ready;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; req[k] = 1'b1; we[k] = 1'b1;
      addr[k] = 17'h0; wdata[k] = 32'h0; be[k] = 4'hF;
    end
    mem_init = 1'b1;
    step();
    mem_init = 1'b0;
    sample();
    chk("reset_ready", 32'(ready[0]), 32'h1);
    chk("reset_sram_we", 32'(sram_we[0]), 32'hF);
    chk("reset_rdata", rdata[0], 32'h0);
    step();
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    sample();
    step();

    // WAIT=2 load of word 4; be is irrelevant for loads
    oe0 = oe_lo[0]; dq0 = dqoe_hi[0];
    do_xfer(0, 1'b1, 17'h00010, 32'h0, 4'b0101, lat, as);
    chk("load_latency", 32'(lat), 32'd5);
    chk("load_sram_a", 32'(as), 32'h0004);
    chk("load_rdata", rdata[0], 32'hDEADBEEF);
    chk("load_oe_cycles", 32'(oe_lo[0] - oe0), 32'd2);
    chk("load_dqoe_cycles", 32'(dqoe_hi[0] - dq0), 32'd0);

    // store lane 2 of word 8
    we0 = we_lo[0]; dq0 = dqoe_hi[0];
    do_xfer(0, 1'b0, 17'h00022, 32'h11223344, 4'b1011, lat, as);
    chk("store_latency", 32'(lat), 32'd5);
    chk("store_we_cycles", 32'(we_lo[0] - we0), 32'd2);
    chk("store_dqoe_cycles", 32'(dqoe_hi[0] - dq0), 32'd4);
    chk("store_word8", sram[0][8], 32'hC022F75A);
    chk("store_rdata_kept", rdata[0], 32'hDEADBEEF);

    // store with no lanes enabled
    we0 = we_lo[0];
    do_xfer(0, 1'b0, 17'h00024, 32'hFFFFFFFF, 4'b1111, lat, as);
    chk("nolane_latency", 32'(lat), 32'd5);
    chk("nolane_we_cycles", 32'(we_lo[0] - we0), 32'd0);
    chk("nolane_word9", sram[1 - 1][9], 32'hC009F65A);

    // WAIT=1 back-to-back with req held low; next descriptor staged mid-transfer
    n_rdy = 0;
    we[1] = 1'b1; addr[1] = 17'h0000C; wdata[1] = 32'h0; be[1] = 4'hF; req[1] = 1'b0;
    step();
    for (int c = 1; c <= 16; c++) begin
      if (c == 2) begin
        we[1] = 1'b0; addr[1] = 17'h00014; wdata[1] = 32'hCAFEF00D; be[1] = 4'b0000;
      end
      if (c == 7) begin
        we[1] = 1'b1; addr[1] = 17'h00017; wdata[1] = 32'h0; be[1] = 4'b1111;
      end
      if (c == 12) req[1] = 1'b1;
      sample();
      if (!ready[1]) begin
        if (n_rdy < 3) rdy_cyc[n_rdy] = c;
        n_rdy++;
      end
      if (c == 5) chk("b2b_first_rdata", rdata[1], 32'hC103FC5A);
      step();
    end
    chk("b2b_ready_count", 32'(n_rdy), 32'd3);
    chk("b2b_ready_1", 32'(rdy_cyc[0]), 32'd4);
    chk("b2b_ready_2", 32'(rdy_cyc[1]), 32'd9);
    chk("b2b_ready_3", 32'(rdy_cyc[2]), 32'd14);
    chk("b2b_last_rdata", rdata[1], 32'hCAFEF00D);

    // reset during ACCESS of a store aborts it
    we[0] = 1'b0; addr[0] = 17'h00030; wdata[0] = 32'h55AA55AA; be[0] = 4'b0000; req[0] = 1'b0;
    step();
    req[0] = 1'b1;
    sample();
    step();
    sample();
    chk("abort_in_access", 32'(sram_we[0]), 32'h0);
    step();
    rst[0] = 1'b0;
    #1;
    chk("abort_sram_we", 32'(sram_we[0]), 32'hF);
    chk("abort_dq_oe", 32'(sram_dq_oe[0]), 32'h0);
    chk("abort_ce", 32'(sram_ce[0]), 32'h1);
    chk("abort_rdata", rdata[0], 32'h0);
    sample();
    step();
    rst[0] = 1'b1;
    saw_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (!ready[0]) saw_ready = 1'b1;
      step();
    end
    chk("abort_no_ready", 32'(saw_ready), 32'h0);
    do_xfer(0, 1'b1, 17'h00010, 32'h0, 4'hF, lat, as);
    chk("post_reset_latency", 32'(lat), 32'd5);
    chk("post_reset_rdata", rdata[0], 32'hDEADBEEF);

    // WAIT=15 load of word 7
    oe0 = oe_lo[2];
    do_xfer(2, 1'b1, 17'h0001C, 32'h0, 4'h0, lat, as);
    chk("w15_latency", 32'(lat), 32'd18);
    chk("w15_oe_cycles", 32'(oe_lo[2] - oe0), 32'd15);
    chk("w15_rdata", rdata[2], 32'hC207F85A);

    sample();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WAIT, default 2: number of ACCESS-state cycles per transfer, legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, ACTIVE LOW.
REQ-004 SHALL have port req  input  1  transfer request, ACTIVE LOW.
REQ-005 SHALL have port we  input  1  low = store, high = load, ACTIVE LOW.
REQ-006 SHALL have port addr  input  17  byte address; bits [16:2] select the word, bits [1:0] are ignored.
REQ-007 SHALL have port wdata  input  32  store data, byte lane i = wdata[8i+7:8i].
REQ-008 SHALL have port be  input  4  store byte enables, ACTIVE LOW, one per lane.
REQ-009 SHALL have port rdata  output  32  load data.
REQ-010 SHALL have port ready  output  1  transfer-complete pulse, ACTIVE LOW.
REQ-011 SHALL have port sram_a  output  15  SRAM word address.
REQ-012 SHALL have port sram_dq_o  output  32  SRAM write data.
REQ-013 SHALL have port sram_dq_i  input  32  SRAM read data.
REQ-014 SHALL have port sram_dq_oe  output  1  high = drive sram_dq_o onto the data bus.
REQ-015 SHALL have port sram_ce  output  1  chip enable, ACTIVE LOW.
REQ-016 SHALL have port sram_oe  output  1  output enable, ACTIVE LOW.
REQ-017 SHALL have port sram_we  output  4  per-lane write enables, ACTIVE LOW.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS, HOLD, RESP.
REQ-019 IDLE: on a rising edge with req=0, SHALL latch we, addr[16:2], wdata and be, then go to SETUP; with req=1 it SHALL stay in IDLE.
REQ-020 SETUP (1 cycle): SHALL drive sram_ce=0, sram_a=latched address and, for a store, sram_dq_oe=1 with sram_dq_o=latched wdata; strobes stay high; next state is ACCESS.
REQ-021 ACCESS (WAIT cycles, 4-bit down-counter loaded with WAIT-1): load SHALL drive sram_oe=0; store SHALL drive sram_we[i]=be[i] from the latched value; address and data are held.
REQ-022 On the last ACCESS cycle of a load, SHALL capture sram_dq_i into the rdata register; next state is HOLD.
REQ-023 HOLD (1 cycle): SHALL return sram_oe and sram_we to all high while sram_ce, sram_a and the store data/sram_dq_oe are held; next state is RESP.
REQ-024 RESP (1 cycle): SHALL drive ready=0 with sram_ce=1 and sram_dq_oe=0; next state is IDLE.
REQ-025 Latency SHALL be ready=0 exactly 3+WAIT cycles after the edge that accepts req.
REQ-026 req, we, addr, wdata and be SHALL be ignored outside IDLE; changes to them SHALL NOT affect an in-flight transfer.
REQ-027 req held low continuously SHALL give back-to-back transfers, each separated by exactly one IDLE cycle.
REQ-028 A load SHALL return all 4 lanes regardless of be; lane selection and sign/zero extension are the requester's job.
REQ-029 A store with be=4'b1111 (no lanes enabled) SHALL run the full FSM with sram_we held all high, then pulse ready.
REQ-030 rdata SHALL hold its value until the next load capture; stores SHALL NOT modify rdata.
REQ-031 sram_dq_oe and sram_oe SHALL never both be active in the same cycle.
REQ-032 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-033 rst=0 SHALL immediately (asynchronously) force state=IDLE, ready=1, sram_ce=1, sram_oe=1, sram_we=4'b1111, sram_dq_oe=0, sram_a=0, sram_dq_o=0, rdata=0, and counter=0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer with no ready pulse; the first req sampled after rst rises SHALL start a fresh transfer.

Verification
REQ-035 WAIT=2; load addr=17'h00010 with the SRAM model returning 32'hDEADBEEF -> sram_a=15'h0004, sram_oe low for 2 cycles, ready=0 on cycle 5, rdata=32'hDEADBEEF.
REQ-036 Store addr=17'h00022, wdata=32'h11223344, be=4'b1011 -> sram_we=4'b1011 for WAIT cycles, sram_dq_oe high for SETUP through HOLD; only lane 2 of word 8 changes; rdata unchanged.
REQ-037 Store with be=4'b1111 -> sram_we never low, ready pulses on cycle 3+WAIT, memory contents unchanged.
REQ-038 req held low for 3 transfers at WAIT=1 -> ready pulses on cycles 4, 9 and 14; inputs changed mid-transfer have no effect on the in-flight transfer.
REQ-039 rst pulsed low during ACCESS of a store -> all strobes high and sram_dq_oe=0 in the same cycle, no ready pulse; the next load completes normally.
REQ-040 WAIT=15 load -> sram_oe low for exactly 15 cycles, ready on cycle 18; an assertion checks sram_oe and sram_dq_oe are never active together.
